// File: rtl/alu_pkg.sv
// Shared encodings for the PI-path ALU: source selects, sequencer states, data width.
package alu_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned SEL_W  = 3;

  localparam logic [SEL_W-1:0] SRC1_ACCUM  = 3'b000;
  localparam logic [SEL_W-1:0] SRC1_ITERM  = 3'b001;
  localparam logic [SEL_W-1:0] SRC1_ERROR  = 3'b010;
  localparam logic [SEL_W-1:0] SRC1_ERRDIV = 3'b011;
  localparam logic [SEL_W-1:0] SRC1_FWD    = 3'b100;

  localparam logic [SEL_W-1:0] SRC0_MEAS   = 3'b000;
  localparam logic [SEL_W-1:0] SRC0_INTGRL = 3'b001;
  localparam logic [SEL_W-1:0] SRC0_ICOMP  = 3'b010;
  localparam logic [SEL_W-1:0] SRC0_PCOMP  = 3'b011;
  localparam logic [SEL_W-1:0] SRC0_PTERM  = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ERR  = 3'd1,
    ST_INTG = 3'd2,
    ST_ICMP = 3'd3,
    ST_PCMP = 3'd4,
    ST_ACC1 = 3'd5,
    ST_ACC2 = 3'd6
  } state_t;

  typedef struct packed {
    logic [SEL_W-1:0] src1sel;
    logic [SEL_W-1:0] src0sel;
    logic             multiply;
    logic             saturate;
    logic             sub;
    logic             mult2;
    logic             mult4;
  } alu_ctrl_t;

endpackage

// File: rtl/alu_seq.sv
// Six-step PI update microsequencer: drives ALU selects/modes and stores each
// step's result in the operand registers that feed back into the ALU.
module alu_seq
  import alu_pkg::*;
#(
  parameter bit SAT_INTGRL = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [DATA_W-1:0]   target,
  input  logic                clr_intgrl,
  input  logic [1:0]          igain,
  input  logic [DATA_W-1:0]   dst,
  output logic [SEL_W-1:0]    src1sel,
  output logic [SEL_W-1:0]    src0sel,
  output logic                multiply,
  output logic                saturate,
  output logic                sub,
  output logic                mult2,
  output logic                mult4,
  output logic [DATA_W-1:0]   Accum,
  output logic [DATA_W-1:0]   Error,
  output logic [DATA_W-1:0]   Intgrl,
  output logic [DATA_W-1:0]   Icomp,
  output logic [DATA_W-1:0]   Pcomp,
  output logic [DATA_W-1:0]   ctrl_out,
  output logic                busy,
  output logic                done
);

  state_t    state, state_nxt;
  alu_ctrl_t ctrl, ctrl_nxt;
  logic      clr_pend;

  // State register; control lines are registered from the next state so they
  // line up with the state they describe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      ctrl  <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      ctrl  <= ctrl_nxt;
      busy  <= (state_nxt != ST_IDLE);
    end
  end

  always_comb begin
    state_nxt = state;
    ctrl_nxt  = '0;
    unique case (state)
      ST_IDLE: if (start) state_nxt = ST_ERR;
      ST_ERR:  state_nxt = ST_INTG;
      ST_INTG: state_nxt = ST_ICMP;
      ST_ICMP: state_nxt = ST_PCMP;
      ST_PCMP: state_nxt = ST_ACC1;
      ST_ACC1: state_nxt = ST_ACC2;
      ST_ACC2: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase

    case (state_nxt)
      ST_ERR: begin
        ctrl_nxt.src1sel  = SRC1_ACCUM;
        ctrl_nxt.src0sel  = SRC0_MEAS;
        ctrl_nxt.sub      = 1'b1;
        ctrl_nxt.saturate = 1'b1;
      end
      ST_INTG: begin
        ctrl_nxt.src1sel  = SRC1_ERRDIV;
        ctrl_nxt.src0sel  = SRC0_INTGRL;
        ctrl_nxt.saturate = SAT_INTGRL;
      end
      ST_ICMP: begin
        ctrl_nxt.src1sel  = SRC1_ITERM;
        ctrl_nxt.src0sel  = SRC0_INTGRL;
        ctrl_nxt.multiply = 1'b1;
        // x4 takes priority when both gain bits are set
        ctrl_nxt.mult4    = igain[1];
        ctrl_nxt.mult2    = igain[0] & ~igain[1];
      end
      ST_PCMP: begin
        ctrl_nxt.src1sel  = SRC1_ERROR;
        ctrl_nxt.src0sel  = SRC0_PTERM;
        ctrl_nxt.multiply = 1'b1;
      end
      ST_ACC1: begin
        ctrl_nxt.src1sel  = SRC1_FWD;
        ctrl_nxt.src0sel  = SRC0_PCOMP;
        ctrl_nxt.saturate = 1'b1;
      end
      ST_ACC2: begin
        ctrl_nxt.src1sel  = SRC1_ACCUM;
        ctrl_nxt.src0sel  = SRC0_ICOMP;
        ctrl_nxt.saturate = 1'b1;
      end
      default: ;
    endcase
  end

  assign src1sel  = ctrl.src1sel;
  assign src0sel  = ctrl.src0sel;
  assign multiply = ctrl.multiply;
  assign saturate = ctrl.saturate;
  assign sub      = ctrl.sub;
  assign mult2    = ctrl.mult2;
  assign mult4    = ctrl.mult4;

  // Operand register bank; integrator clears are deferred to an IDLE cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      Accum    <= '0;
      Error    <= '0;
      Intgrl   <= '0;
      Icomp    <= '0;
      Pcomp    <= '0;
      ctrl_out <= '0;
      done     <= 1'b0;
      clr_pend <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == ST_IDLE) begin
        clr_pend <= 1'b0;
        if (clr_pend || clr_intgrl) Intgrl <= '0;
        if (start) Accum <= target;
      end else begin
        clr_pend <= clr_pend | clr_intgrl;
      end
      case (state)
        ST_ERR:  Error  <= dst;
        ST_INTG: Intgrl <= dst;
        ST_ICMP: Icomp  <= dst;
        ST_PCMP: Pcomp  <= dst;
        ST_ACC1: Accum  <= dst;
        ST_ACC2: begin
          Accum    <= dst;
          ctrl_out <= dst;
          done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: phase-table reference model checked every cycle, directed
// schedule scenarios with literal expectations, then randomized traffic.
module tb_alu_seq;

  localparam bit SAT = 1'b1;

  logic        clk = 1'b0;
  logic        rst_n, start, clr_intgrl;
  logic [15:0] target, dst;
  logic [1:0]  igain;
  logic [2:0]  src1sel, src0sel;
  logic        multiply, saturate, sub, mult2, mult4, busy, done;
  logic [15:0] Accum, Error, Intgrl, Icomp, Pcomp, ctrl_out;

  always #5 clk = ~clk;

  alu_seq #(.SAT_INTGRL(SAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .target(target),
    .clr_intgrl(clr_intgrl), .igain(igain), .dst(dst),
    .src1sel(src1sel), .src0sel(src0sel), .multiply(multiply),
    .saturate(saturate), .sub(sub), .mult2(mult2), .mult4(mult4),
    .Accum(Accum), .Error(Error), .Intgrl(Intgrl), .Icomp(Icomp),
    .Pcomp(Pcomp), .ctrl_out(ctrl_out), .busy(busy), .done(done)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: phase 0 = idle, 1..6 = schedule steps.
  int          m_phase = 0;
  logic [15:0] m_accum = '0, m_error = '0, m_intgrl = '0, m_icomp = '0;
  logic [15:0] m_pcomp = '0, m_ctrl = '0;
  logic        m_pend = 1'b0, m_done = 1'b0;

  logic [2:0] t_src1 [7] = '{3'd0, 3'd0, 3'd3, 3'd1, 3'd2, 3'd4, 3'd0};
  logic [2:0] t_src0 [7] = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd4, 3'd3, 3'd2};
  logic       t_mul  [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  logic       t_sat  [7] = '{1'b0, 1'b1, SAT,  1'b0, 1'b0, 1'b1, 1'b1};
  logic       t_sub  [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    int nxt;
    if (!rst_n) begin
      m_phase = 0; m_accum = '0; m_error = '0; m_intgrl = '0; m_icomp = '0;
      m_pcomp = '0; m_ctrl = '0; m_pend = 1'b0; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      nxt = m_phase;
      case (m_phase)
        0: begin
          if (m_pend || clr_intgrl) m_intgrl = '0;
          m_pend = 1'b0;
          if (start) begin m_accum = target; nxt = 1; end
        end
        1: m_error  = dst;
        2: m_intgrl = dst;
        3: m_icomp  = dst;
        4: m_pcomp  = dst;
        5: m_accum  = dst;
        6: begin m_accum = dst; m_ctrl = dst; m_done = 1'b1; end
        default: ;
      endcase
      if (m_phase != 0) begin
        m_pend = m_pend | clr_intgrl;
        nxt = (m_phase == 6) ? 0 : m_phase + 1;
      end
      m_phase = nxt;
    end
  endtask

  task automatic compare_all();
    logic e_m2, e_m4;
    e_m2 = (m_phase == 3) && (igain == 2'b01);
    e_m4 = (m_phase == 3) && igain[1];
    chk("src1sel",  16'(src1sel),  16'(t_src1[m_phase]));
    chk("src0sel",  16'(src0sel),  16'(t_src0[m_phase]));
    chk("multiply", 16'(multiply), 16'(t_mul[m_phase]));
    chk("saturate", 16'(saturate), 16'(t_sat[m_phase]));
    chk("sub",      16'(sub),      16'(t_sub[m_phase]));
    chk("mult2",    16'(mult2),    16'(e_m2));
    chk("mult4",    16'(mult4),    16'(e_m4));
    chk("Accum",    Accum,    m_accum);
    chk("Error",    Error,    m_error);
    chk("Intgrl",   Intgrl,   m_intgrl);
    chk("Icomp",    Icomp,    m_icomp);
    chk("Pcomp",    Pcomp,    m_pcomp);
    chk("ctrl_out", ctrl_out, m_ctrl);
    chk("busy",     16'(busy), 16'(m_phase != 0));
    chk("done",     16'(done), 16'(m_done));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; clr_intgrl = 1'b0;
    target = '0; dst = 16'hFFFF; igain = 2'b00;

    // Reset, then idle with dst ignored
    repeat (3) step();
    rst_n = 1'b1;
    step();
    chk("idle_busy", 16'(busy), 16'h0);
    chk("idle_accum", Accum, 16'h0000);
    chk("idle_ctrl", ctrl_out, 16'h0000);

    // Full schedule with literal results
    igain = 2'b01; target = 16'h0100; start = 1'b1;
    step();
    start = 1'b0;
    chk("c1_src1", 16'(src1sel), 16'h0);
    chk("c1_src0", 16'(src0sel), 16'h0);
    chk("c1_sub", 16'(sub), 16'h1);
    chk("c1_sat", 16'(saturate), 16'h1);
    chk("c1_accum", Accum, 16'h0100);
    dst = 16'h0040; step();
    chk("c2_error", Error, 16'h0040);
    dst = 16'h0050; step();
    chk("c3_intgrl", Intgrl, 16'h0050);
    chk("c3_mult2", 16'(mult2), 16'h1);
    chk("c3_mult4", 16'(mult4), 16'h0);
    dst = 16'h0020; step();
    chk("c4_icomp", Icomp, 16'h0020);
    chk("c4_mult2", 16'(mult2), 16'h0);
    dst = 16'h0300; step();
    chk("c5_pcomp", Pcomp, 16'h0300);
    dst = 16'h0310; step();
    chk("c6_accum", Accum, 16'h0310);
    chk("c6_done", 16'(done), 16'h0);
    dst = 16'h0330; step();
    chk("c7_ctrl", ctrl_out, 16'h0330);
    chk("c7_done", 16'(done), 16'h1);
    chk("c7_busy", 16'(busy), 16'h0);
    start = 1'b1; target = 16'h0200;
    step();
    start = 1'b0;
    chk("c8_busy", 16'(busy), 16'h1);
    chk("c8_sub", 16'(sub), 16'h1);
    chk("c8_done", 16'(done), 16'h0);
    chk("c8_accum", Accum, 16'h0200);
    repeat (6) begin dst = 16'($urandom); step(); end

    // x4 gain, ignored start and deferred integrator clear
    igain = 2'b11; target = 16'h0001; start = 1'b1;
    step();
    start = 1'b0; dst = 16'($urandom); step();
    dst = 16'h1234; step();
    chk("r3_intgrl", Intgrl, 16'h1234);
    chk("r3_mult4", 16'(mult4), 16'h1);
    chk("r3_mult2", 16'(mult2), 16'h0);
    start = 1'b1; clr_intgrl = 1'b1; step();
    start = 1'b0; clr_intgrl = 1'b0;
    chk("r4_src1", 16'(src1sel), 16'h2);
    chk("r4_busy", 16'(busy), 16'h1);
    step(); step(); step();
    chk("r7_done", 16'(done), 16'h1);
    chk("r7_intgrl", Intgrl, 16'h1234);
    step();
    chk("r8_intgrl", Intgrl, 16'h0000);
    chk("r8_busy", 16'(busy), 16'h0);

    // Reset in the middle of a schedule
    igain = 2'b01; target = 16'h0ABC; start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) begin dst = 16'($urandom); step(); end
    rst_n = 1'b0; step();
    chk("rst_busy", 16'(busy), 16'h0);
    chk("rst_accum", Accum, 16'h0000);
    chk("rst_error", Error, 16'h0000);
    chk("rst_done", 16'(done), 16'h0);
    chk("rst_src0", 16'(src0sel), 16'h0);
    rst_n = 1'b1; step();
    chk("post_rst_done1", 16'(done), 16'h0);
    step();
    chk("post_rst_done2", 16'(done), 16'h0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst_n      = ($urandom_range(199) != 0);
      start      = ($urandom_range(3) == 0);
      clr_intgrl = ($urandom_range(15) == 0);
      target     = 16'($urandom);
      dst        = 16'($urandom);
      if (m_phase == 0 && $urandom_range(3) == 0) igain = 2'($urandom_range(3));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
